// File: rtl/uart_receiver_if.sv
// Receive-side signal bundle: serial line in, byte/valid/ready handshake and status out.
// master = receiver, slave = line driver and byte consumer.
interface uart_receiver_if;
   logic       uart_rx;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;
   logic       frame_error;
   logic       overrun;

   modport master (
      input  uart_rx, rx_ready,
      output rx_data, rx_valid, frame_error, overrun
   );

   modport slave (
      output uart_rx, rx_ready,
      input  rx_data, rx_valid, frame_error, overrun
   );
endinterface

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: midpoint sampling, valid/ready byte handoff, framing error and overrun flags.
// One bit period is DELAY_FRAMES+1 clk cycles.
module uart_receiver #(
   parameter int DELAY_FRAMES = 234
) (
   input logic            clk,
   input logic            rst,
   uart_receiver_if.master bus
);
   localparam int CW = (DELAY_FRAMES < 1) ? 1 : $clog2(DELAY_FRAMES + 1);
   localparam logic [CW-1:0] HALF_C = CW'(DELAY_FRAMES / 2);
   localparam logic [CW-1:0] TERM_C = CW'(DELAY_FRAMES);

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

   state_t          state, state_n;
   logic [CW-1:0]   cnt, cnt_n;
   logic [2:0]      bit_idx, bit_idx_n;
   logic [7:0]      shreg, shreg_n;
   logic            sync1, rx_s;
   logic [7:0]      data_q, data_n;
   logic            valid_q, valid_n;
   logic            fe_q, fe_n;
   logic            ov_q, ov_n;

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= '0;
         bit_idx <= '0;
         shreg   <= '0;
         sync1   <= 1'b1;
         rx_s    <= 1'b1;
         data_q  <= '0;
         valid_q <= 1'b0;
         fe_q    <= 1'b0;
         ov_q    <= 1'b0;
      end else begin
         state   <= state_n;
         cnt     <= cnt_n;
         bit_idx <= bit_idx_n;
         shreg   <= shreg_n;
         sync1   <= bus.uart_rx;
         rx_s    <= sync1;
         data_q  <= data_n;
         valid_q <= valid_n;
         fe_q    <= fe_n;
         ov_q    <= ov_n;
      end
   end

   always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      bit_idx_n = bit_idx;
      shreg_n   = shreg;
      data_n    = data_q;
      valid_n   = valid_q;
      fe_n      = 1'b0;
      ov_n      = ov_q;

      // Consumer handshake; a delivery in the same cycle overrides it below.
      if (valid_q && bus.rx_ready) valid_n = 1'b0;

      unique case (state)
         IDLE: begin
            cnt_n = '0;
            if (!rx_s) state_n = START;
         end
         START: begin
            if (cnt == HALF_C) begin
               cnt_n = '0;
               if (!rx_s) begin
                  state_n   = DATA;
                  bit_idx_n = '0;
               end else begin
                  state_n = IDLE;
               end
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         DATA: begin
            if (cnt == TERM_C) begin
               shreg_n[bit_idx] = rx_s;
               cnt_n            = '0;
               bit_idx_n        = bit_idx + 3'd1;
               if (bit_idx == 3'd7) state_n = STOP;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         STOP: begin
            if (cnt == TERM_C) begin
               cnt_n = '0;
               // Leaving at the stop-bit midpoint leaves half a bit to catch a back-to-back start edge.
               if (rx_s) begin
                  state_n = IDLE;
                  if (!valid_q || bus.rx_ready) begin
                     data_n  = shreg;
                     valid_n = 1'b1;
                  end else begin
                     ov_n = 1'b1;
                  end
               end else begin
                  fe_n    = 1'b1;
                  state_n = WAIT_IDLE;
               end
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         WAIT_IDLE: begin
            cnt_n = '0;
            if (rx_s) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   assign bus.rx_data     = data_q;
   assign bus.rx_valid    = valid_q;
   assign bus.frame_error = fe_q;
   assign bus.overrun     = ov_q;
endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: frames, glitch, framing error, overrun, reset, byte stream.
module tb_uart_receiver;
   localparam int D   = 234;
   localparam int BIT = D + 1;
   localparam int FRM = 10 * BIT;
   // Drive negedge of start bit to the negedge after the delivering edge: 2 sync + 1 idle + (D/2+1) + 9 bit periods.
   localparam int LAT = 3 + (D / 2 + 1) + 9 * BIT;

   logic clk = 1'b0;
   logic rst;
   uart_receiver_if bus();

   uart_receiver #(.DELAY_FRAMES(D)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   int   cyc = 0;
   int   t_start = 0;
   int   t_rise = 0;
   int   fe_cnt = 0;
   int   fe_double = 0;
   logic v_prev = 1'b0;
   logic fe_prev = 1'b0;
   bit   collect = 1'b0;
   logic [7:0] got_q[$];

   int errors = 0;
   int checks = 0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (bus.rx_valid && !v_prev) t_rise <= cyc;
      v_prev  <= bus.rx_valid;
      if (bus.frame_error) fe_cnt <= fe_cnt + 1;
      if (bus.frame_error && fe_prev) fe_double <= fe_double + 1;
      fe_prev <= bus.frame_error;
      if (collect && bus.rx_valid && bus.rx_ready) got_q.push_back(bus.rx_data);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Serial transmitter model: start, 8 data LSB first, stop; optional ready pulse just before delivery.
   task automatic send_frame(input logic [7:0] b, input logic stop, input bit rdy_pulse, input int ncyc);
      int idx;
      logic [2:0] bi;
      for (int c = 0; c < ncyc; c++) begin
         @(negedge clk);
         if (c == 0) t_start = cyc;
         idx = c / BIT;
         bi  = 3'(idx - 1);
         if (idx == 0)      bus.uart_rx = 1'b0;
         else if (idx <= 8) bus.uart_rx = b[bi];
         else               bus.uart_rx = stop;
         if (rdy_pulse) bus.rx_ready = (c >= LAT - 4 && c < LAT);
      end
   endtask

   task automatic idle(input int n);
      bus.uart_rx = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   task automatic consume();
      @(negedge clk);
      bus.rx_ready = 1'b1;
      @(negedge clk);
      bus.rx_ready = 1'b0;
   endtask

   initial begin
      string s;
      int d;
      s = "Victor Padial ";
      rst = 1'b1;
      bus.uart_rx = 1'b1;
      bus.rx_ready = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("reset_data",  32'(bus.rx_data), 32'h00);
      chk("reset_valid", 32'(bus.rx_valid), 32'd0);
      chk("reset_fe",    32'(bus.frame_error), 32'd0);
      chk("reset_ovr",   32'(bus.overrun), 32'd0);
      idle(20);

      // 0x56 with consumer not ready
      send_frame(8'h56, 1'b1, 1'b0, FRM);
      idle(5);
      chk("v56_valid", 32'(bus.rx_valid), 32'd1);
      chk("v56_data",  32'(bus.rx_data), 32'h56);
      chk("v56_fe",    32'(fe_cnt), 32'd0);
      chk("v56_ovr",   32'(bus.overrun), 32'd0);
      d = t_rise - t_start;
      chk("v56_latency_window", 32'(d >= LAT - 3 && d <= LAT + 2), 32'd1);
      consume();
      chk("v56_consumed", 32'(bus.rx_valid), 32'd0);
      chk("v56_data_hold", 32'(bus.rx_data), 32'h56);

      // 50-cycle glitch must be rejected
      bus.uart_rx = 1'b0;
      repeat (50) @(negedge clk);
      idle(300);
      chk("glitch_valid", 32'(bus.rx_valid), 32'd0);
      chk("glitch_fe",    32'(fe_cnt), 32'd0);
      chk("glitch_data",  32'(bus.rx_data), 32'h56);

      // 0xA5 with low stop bit, then a good 0x3C
      send_frame(8'hA5, 1'b0, 1'b0, FRM);
      idle(300);
      chk("fe_pulses", 32'(fe_cnt), 32'd1);
      chk("fe_valid",  32'(bus.rx_valid), 32'd0);
      chk("fe_data",   32'(bus.rx_data), 32'h56);
      send_frame(8'h3C, 1'b1, 1'b0, FRM);
      idle(5);
      chk("after_fe_valid", 32'(bus.rx_valid), 32'd1);
      chk("after_fe_data",  32'(bus.rx_data), 32'h3C);
      consume();

      // Back-to-back with no consumer: second byte lost
      send_frame(8'h11, 1'b1, 1'b0, FRM);
      send_frame(8'h22, 1'b1, 1'b0, FRM);
      idle(5);
      chk("ovr_data",  32'(bus.rx_data), 32'h11);
      chk("ovr_valid", 32'(bus.rx_valid), 32'd1);
      chk("ovr_flag",  32'(bus.overrun), 32'd1);
      idle(100);
      chk("ovr_sticky", 32'(bus.overrun), 32'd1);

      // Reset in the middle of data bit 4
      send_frame(8'hFF, 1'b1, 1'b0, 5 * BIT + 120);
      @(negedge clk);
      rst = 1'b1;
      bus.uart_rx = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("midrst_data",  32'(bus.rx_data), 32'h00);
      chk("midrst_valid", 32'(bus.rx_valid), 32'd0);
      chk("midrst_fe",    32'(bus.frame_error), 32'd0);
      chk("midrst_ovr",   32'(bus.overrun), 32'd0);
      idle(2 * BIT);
      chk("midrst_no_frame", 32'(bus.rx_valid), 32'd0);
      send_frame(8'h7E, 1'b1, 1'b0, FRM);
      idle(5);
      chk("post_rst_valid", 32'(bus.rx_valid), 32'd1);
      chk("post_rst_data",  32'(bus.rx_data), 32'h7E);
      consume();

      // Back-to-back with ready pulsed at the second delivery
      send_frame(8'h11, 1'b1, 1'b0, FRM);
      send_frame(8'h22, 1'b1, 1'b1, FRM);
      idle(5);
      chk("b2b_data",  32'(bus.rx_data), 32'h22);
      chk("b2b_valid", 32'(bus.rx_valid), 32'd1);
      chk("b2b_ovr",   32'(bus.overrun), 32'd0);
      consume();

      // Continuous stream from the transmitter model, consumer always ready
      @(negedge clk);
      bus.rx_ready = 1'b1;
      collect = 1'b1;
      for (int i = 0; i < 16; i++) send_frame(s[i % 14], 1'b1, 1'b0, FRM);
      idle(20);
      collect = 1'b0;
      bus.rx_ready = 1'b0;
      chk("stream_count", 32'(got_q.size()), 32'd16);
      for (int i = 0; i < 16; i++) begin
         if (i < got_q.size()) chk($sformatf("stream_byte%0d", i), 32'(got_q[i]), 32'(s[i % 14]));
      end
      chk("stream_ovr",  32'(bus.overrun), 32'd0);
      chk("total_fe",    32'(fe_cnt), 32'd1);
      chk("fe_one_cycle", 32'(fe_double), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
